rxdpram_wr_ctrl: RTL and testbench

RXDPRAM_WR_CTRL -- requirements
Module: rxdpram_wr_ctrl

---
 rtl/rxdpram_wr_ctrl.sv | 87 ++++++++
 tb/tb_rxdpram_wr_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rxdpram_wr_ctrl.sv
// rxdpram_wr_ctrl: writes rx stream frames into the rx dual-port RAM and hands full frames to the cache controller.
// Define RXDPRAM_DONE_SYNC_EN to pass rxdpram_wr_done through a 2-flop synchroniser.
module rxdpram_wr_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = 4096
) (
  input  logic                  rxclka,
  input  logic                  rxrsta,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_sof,
  output logic                  rxdpram_wea_a0,
  output logic [ADDR_WIDTH-1:0] rxdpram_addra_a0,
  output logic [DATA_WIDTH-1:0] rxdpram_din_a0,
  output logic                  rxdpram_wr_int,
  input  logic                  rxdpram_wr_done,
  output logic                  rx_busy,
  output logic [15:0]           rx_frame_cnt,
  output logic [15:0]           rx_drop_cnt
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] FILL      = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_WORDS - 1);
  logic [1:0] state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, wr_addr;
  logic sof_acc, fill_acc, wr, last, drop, done_edge, done_fire;
`ifdef RXDPRAM_DONE_SYNC_EN
  logic done_s1, done_s2, done_q;
  always_ff @(posedge rxclka or posedge rxrsta) begin
    if (rxrsta) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_s1 <= rxdpram_wr_done;
      done_s2 <= done_s1;
      done_q  <= done_s2;
    end
  end
  assign done_edge = done_s2 & ~done_q;
`else
  logic done_q;
  always_ff @(posedge rxclka or posedge rxrsta) begin
    if (rxrsta) done_q <= 1'b0;
    else        done_q <= rxdpram_wr_done;
  end
  assign done_edge = rxdpram_wr_done & ~done_q;
`endif
  // a sof word restarts at address 0 from either IDLE or FILL; WAIT_DONE drops everything
  always_comb begin
    sof_acc   = rx_valid & rx_sof & (state != WAIT_DONE);
    fill_acc  = rx_valid & ~rx_sof & (state == FILL);
    wr        = sof_acc | fill_acc;
    drop      = rx_valid & ~wr;
    wr_addr   = sof_acc ? '0 : cnt;
    last      = wr & (wr_addr == LAST);
    done_fire = (state == WAIT_DONE) & done_edge;
    state_nxt = done_fire ? IDLE : last ? WAIT_DONE : wr ? FILL : state;
  end
  always_ff @(posedge rxclka or posedge rxrsta) begin
    if (rxrsta) begin
      state            <= IDLE;
      cnt              <= '0;
      rxdpram_wea_a0   <= 1'b0;
      rxdpram_addra_a0 <= '0;
      rxdpram_din_a0   <= '0;
      rxdpram_wr_int   <= 1'b0;
      rx_busy          <= 1'b0;
      rx_frame_cnt     <= '0;
      rx_drop_cnt      <= '0;
    end else begin
      state          <= state_nxt;
      rx_busy        <= state_nxt != IDLE;
      rxdpram_wea_a0 <= wr;
      if (wr) begin
        rxdpram_addra_a0 <= wr_addr;
        rxdpram_din_a0   <= rx_data;
        cnt              <= wr_addr + 1'b1;
      end
      rxdpram_wr_int <= last | (rxdpram_wr_int & ~done_fire);
      rx_frame_cnt   <= rx_frame_cnt + 16'(done_fire);
      if (drop && rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_rxdpram_wr_ctrl.sv
// tb_rxdpram_wr_ctrl: scoreboard bench; expected RAM writes are queued by stimulus and popped by a write monitor.
module tb_rxdpram_wr_ctrl;
`ifdef RXDPRAM_DONE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_sof = 1'b0;
  logic        wea;
  logic [11:0] addra;
  logic [31:0] din;
  logic        wr_int;
  logic        done = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt, drop_cnt;
  int checks = 0;
  int errors = 0;
  int busy_bad = 0;
  logic [43:0] exp_q[$];

  rxdpram_wr_ctrl dut (
    .rxclka(clk), .rxrsta(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof),
    .rxdpram_wea_a0(wea), .rxdpram_addra_a0(addra), .rxdpram_din_a0(din),
    .rxdpram_wr_int(wr_int), .rxdpram_wr_done(done), .rx_busy(busy),
    .rx_frame_cnt(frame_cnt), .rx_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic word(input logic v, input logic s, input logic [31:0] d);
    rx_valid = v;
    rx_sof   = s;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
  endtask

  task automatic wr(input logic s, input int a, input logic [31:0] d);
    logic [11:0] a12;
    a12 = a[11:0];
    exp_q.push_back({a12, d});
    word(1'b1, s, d);
    if (!busy) busy_bad++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && wea) begin
        if (exp_q.size() == 0) chk("unexpected_write", {addra, din}, 64'h0);
        else chk("write", {addra, din}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {wea, addra, din, wr_int, busy, frame_cnt, drop_cnt}, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) word(1'b1, 1'b0, 32'hBAD0 + i);
    chk("idle_drops", drop_cnt, 5);
    chk("idle_busy", busy, 0);
    wr(1'b1, 0, 1);
    for (int i = 2; i <= 4096; i++) begin
      wr(1'b0, i - 1, i);
      if (i == 4095) chk("wr_int_before_last", wr_int, 0);
    end
    chk("wr_int_with_last_wea", {wr_int, wea}, 2'b11);
    chk("busy_throughout", busy_bad, 0);
    for (int i = 0; i < 10; i++) word(1'b1, i[0], 32'hD0D0 + i);
    chk("wait_drops", drop_cnt, 15);
    chk("wait_holds_wr_int", wr_int, 1);
    done = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      done = 1'b0;
      n++;
      if (!wr_int) break;
    end
    chk("done_latency", n, LAT);
    chk("frame_cnt_1", frame_cnt, 1);
    chk("idle_after_done", busy, 0);
    busy_bad = 0;
    done = 1'b1;
    wr(1'b1, 0, 1);
    for (int i = 2; i <= 100; i++) wr(1'b0, i - 1, i);
    wr(1'b1, 0, 5000);
    for (int k = 1; k < 4096; k++) wr(1'b0, k, 5000 + k);
    chk("restart_frame_complete", wr_int, 1);
    chk("restart_no_drops", drop_cnt, 15);
    chk("restart_busy", busy_bad, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("held_done_no_complete", wr_int, 1);
    done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("fallen_done_no_complete", wr_int, 1);
    done = 1'b1;
    for (int i = 0; i < LAT; i++) word(1'b1, 1'b1, 32'hDEAD);
    chk("edge_completes", wr_int, 0);
    chk("frame_cnt_2", frame_cnt, 2);
    chk("edge_word_dropped", drop_cnt, 15 + LAT);
    done = 1'b0;
    wr(1'b1, 0, 32'h7000_0000);
    for (int k = 1; k < 2000; k++) wr(1'b0, k, 32'h7000_0000 + k);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset", {wea, addra, din, wr_int, busy, frame_cnt, drop_cnt}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) word(1'b1, 1'b0, 32'h5150 + i);
    chk("post_reset_needs_sof", drop_cnt, 3);
    wr(1'b1, 0, 32'hABC);
    chk("post_reset_sof_accepted", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
